// File: rtl/dec_digit_serializer_pkg.sv
// Shared types and constants for the decimal digit serializer.
package dec_pkg;

  typedef logic [3:0] bcd_t;

  localparam int DEC_BASE = 10;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    EMIT
  } dec_state_e;

endpackage

// File: rtl/dec_digit_serializer_if.sv
// Word-in / digit-out handshake bundle of the decimal digit serializer.
// slave: the serializer itself; master: the producer/consumer side.
interface dec_digit_serializer_if #(
  parameter int W = 32
);
  import dec_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  bcd_t         out_digit;
  logic         out_last;
  logic         out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_digit, out_last, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_digit, out_last, out_ovf
  );

endinterface

// File: rtl/dec_digit_serializer_div10_step.sv
// Combinational W-bit unsigned divide by ten, restoring long division.
// The partial remainder never exceeds 19 after a shift, so 5 bits suffice,
// and the final remainder always fits in a BCD digit.
module div10_step import dec_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] dividend,
  output logic [W-1:0] quotient,
  output bcd_t         remainder
);

  logic [4:0] part;

  // Shift in one dividend bit per step, subtract ten whenever it fits.
  always_comb begin
    part     = '0;
    quotient = '0;
    for (int i = W - 1; i >= 0; i--) begin
      part = {part[3:0], dividend[i]};
      if (part >= 5'(DEC_BASE)) begin
        quotient[i] = 1'b1;
        part        = part - 5'(DEC_BASE);
      end
    end
    remainder = part[3:0];
  end

endmodule

// File: rtl/dec_digit_serializer.sv
// Binary-to-decimal serializer: accepts one W-bit word, peels off D decimal
// digits (one divide-by-ten per cycle), then streams them MSD first as BCD.
// Optional macro DEC_LZ_SUPPRESS_EN: skip leading zeros (value 0 still emits
// a single 0). Without it all D digits are emitted.
module dec_digit_serializer import dec_pkg::*; #(
  parameter int W = 32,
  parameter int D = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dec_digit_serializer_if.slave bus
);

  localparam int             CW       = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(D - 1);

  dec_state_e    state;
  logic [W-1:0]  work;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ptr;
  bcd_t          dig [D];
  logic          ovf_r;

  logic          in_ready_r;
  logic          out_valid_r;
  bcd_t          out_digit_r;
  logic          out_last_r;
  logic          out_ovf_r;

  logic [W-1:0]  quot;
  bcd_t          rem;
  logic [CW-1:0] start_ptr;
  bcd_t          start_digit;
  logic [CW-1:0] nxt_ptr;

`ifdef DEC_LZ_SUPPRESS_EN
  logic [CW-1:0] msd;
`endif

  div10_step #(.W(W)) u_div (
    .dividend  (work),
    .quotient  (quot),
    .remainder (rem)
  );

  // First digit to present when the last divide step completes; the digit
  // being written this cycle is taken straight from the divider.
  always_comb begin
    start_ptr   = LAST_IDX;
    start_digit = rem;
`ifdef DEC_LZ_SUPPRESS_EN
    if (rem == '0) begin
      start_ptr   = msd;
      start_digit = dig[msd];
    end
`endif
  end

  assign nxt_ptr = ptr - CW'(1);

  // Control FSM, digit buffer and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      ptr         <= '0;
      ovf_r       <= 1'b0;
      for (int i = 0; i < D; i++) dig[i] <= '0;
`ifdef DEC_LZ_SUPPRESS_EN
      msd         <= '0;
`endif
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_digit_r <= '0;
      out_last_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work       <= bus.in_data;
            cnt        <= '0;
`ifdef DEC_LZ_SUPPRESS_EN
            msd        <= '0;
`endif
            in_ready_r <= 1'b0;
            state      <= DIV;
          end
        end

        DIV: begin
          dig[cnt] <= rem;
          work     <= quot;
          cnt      <= cnt + CW'(1);
`ifdef DEC_LZ_SUPPRESS_EN
          if (rem != '0) msd <= cnt;
`endif
          if (cnt == LAST_IDX) begin
            state       <= EMIT;
            ptr         <= start_ptr;
            ovf_r       <= (quot != '0);
            out_valid_r <= 1'b1;
            out_digit_r <= start_digit;
            out_last_r  <= (start_ptr == '0);
            out_ovf_r   <= (quot != '0) && (start_ptr == '0);
          end
        end

        EMIT: begin
          if (bus.out_ready) begin
            if (ptr == '0) begin
              state       <= IDLE;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_ovf_r   <= 1'b0;
            end else begin
              ptr         <= nxt_ptr;
              out_digit_r <= dig[nxt_ptr];
              out_last_r  <= (nxt_ptr == '0);
              out_ovf_r   <= ovf_r && (nxt_ptr == '0);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_digit = out_digit_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_ovf   = out_ovf_r;

endmodule

// File: doc/dec_digit_serializer.md
# dec_digit_serializer

Sequential binary-to-decimal serializer that sits downstream of the parallel divider datapath. It accepts one W-bit unsigned word over a valid/ready handshake. It divides the word by 10 once per cycle to extract decimal digits, buffers them, and streams them most-significant digit first as 4-bit BCD over a second valid/ready handshake. Its output feeds display and UART-print logic.

## Interface
- `W`, 32, input word width in bits (≥4)
- `D`, 10, digit buffer depth = number of divide steps (≥1)
- `clk` input 1 system clock, all logic on rising edge
- `rst_n` input 1 reset; synchronous, active-low
- `in_valid` input 1 input word available
- `in_ready` output 1 block can accept a word
- `in_data` input W unsigned binary word
- `out_valid` output 1 `out_digit` is valid
- `out_ready` input 1 consumer accepts the digit
- `out_digit` output 4 BCD digit, 0–9
- `out_last` output 1 current digit is the least-significant digit
- `out_ovf` output 1 valid with `out_last`; value exceeded D digits (high digits lost)

## Operation
- States: IDLE, DIV, EMIT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`:
    - work ← `in_data`
    - cnt ← 0
    - msd ← 0
    - → DIV
- **DIV**, exactly D cycles, independent of the value. Each cycle:
  - dig[cnt] ← work % 10
  - work ← work / 10
  - if (work % 10) ≠ 0 then msd ← cnt
  - cnt++
  - When cnt==D-1: → EMIT, and ptr ← D-1 (no suppression) or msd (suppression).
  - ovf_r ← (work/10 ≠ 0) on the final step.
- **EMIT**
  - `out_valid`=1, `out_digit`=dig[ptr], `out_last`=(ptr==0), `out_ovf`=ovf_r & (ptr==0).
  - On `out_valid & out_ready`: if ptr==0 → IDLE, else ptr--.
- `in_ready`=0 in DIV and EMIT. No overlap between words.
- Output stability: while `out_valid & !out_ready`, `out_digit`, `out_last` and `out_ovf` are held constant.
- Arithmetic:
  - work is W bits; the quotient by 10 fits in W bits.
  - Remainder is computed in 4 bits, always ≤9.
  - The buffer holds D×4 bits.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `out_digit`=0, `out_last`=0, `out_ovf`=0. Digit buffer, cnt, ptr and ovf_r cleared.
- Input handshake at edge T → DIV during T+1…T+D → `out_valid`=1 from cycle T+D+1.
- Digit k is presented one cycle after digit k-1's handshake when `out_ready` is held high. Sustained rate: 1 digit/cycle.
- `in_ready` returns high the cycle after the last digit's handshake.
- Total occupancy with `out_ready`=1 is D+1+(digits emitted) cycles.
- Reset asserted in any state takes priority: next edge → IDLE with reset values. Partially emitted words are discarded.
- `in_valid` during DIV/EMIT is ignored. It is not latched.

## Configuration
- `DEC_LZ_SUPPRESS_EN` defined:
  - leading zeros are skipped, emission starts at msd;
  - value 0 emits a single digit 0 with `out_last`=1.
- Not defined:
  - all D digits are always emitted, including leading zeros;
  - msd tracking logic is removed.

## Structure
- Package `dec_pkg`:
  - `bcd_t` (logic[3:0])
  - constant `DEC_BASE`=10
  - state enum `dec_state_e` {IDLE, DIV, EMIT}
- Sub-module `div10_step`:
  - combinational W-bit ÷ 10, restoring, outputs quotient[W-1:0] and remainder[3:0];
  - instantiated once and used every DIV cycle.
- Top holds the FSM, counters, digit buffer and handshakes.

## Test plan
- W=32, D=10, input 1234567890, `out_ready`=1 → digits 1,2,3,4,5,6,7,8,9,0; `out_last` only on 0; first `out_valid` at T+11; `out_ovf`=0.
- W=32, D=10, input 0 → with macro: single digit 0, `out_last`=1. Without macro: ten 0 digits, `out_last` on the tenth.
- W=32, D=10, input 4294967295 with macro → 4,2,9,4,9,6,7,2,9,5; then input 7 → single digit 7.
- Backpressure: input 305, `out_ready` low 5 cycles at the first digit → digit 3 held stable, no digits lost or duplicated. Expected stream: 3,0,5 with macro; 0,0,0,0,0,0,0,3,0,5 without.
- Overflow: W=16, D=4, input 65535 → digits 5,5,3,5; `out_ovf`=1 on the last digit only.
- Reset: `rst_n` low for one cycle during DIV step 4 → next cycle `in_ready`=1, `out_valid`=0; a following input of 42 emits correctly.
